rf_multi: RTL

RF_MULTI -- requirements
Module: rf_multi

---
 rtl/rf_multi_if.sv | 31 +++
 rtl/rf_multi.sv | 106 ++++++++++
 2 files changed

// File: rtl/rf_multi_if.sv
// Bus bundle for rf_multi: two combinational read ports, two write ports, clear request and ready.
// A write is accepted on a rising edge only when ready is high and clr is low; ready is low for the whole clear sweep.
interface rf_multi_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
);
    logic             clr;
    logic [AW-1:0]    rd_addr_a;
    logic [AW-1:0]    rd_addr_b;
    logic [WIDTH-1:0] rd_data_a;
    logic [WIDTH-1:0] rd_data_b;
    logic             wr_en_0;
    logic             wr_en_1;
    logic [AW-1:0]    wr_addr_0;
    logic [AW-1:0]    wr_addr_1;
    logic [WIDTH-1:0] wr_data_0;
    logic [WIDTH-1:0] wr_data_1;
    logic             ready;

    modport master (
        output clr, rd_addr_a, rd_addr_b, wr_en_0, wr_en_1,
        output wr_addr_0, wr_addr_1, wr_data_0, wr_data_1,
        input  rd_data_a, rd_data_b, ready
    );

    modport slave (
        input  clr, rd_addr_a, rd_addr_b, wr_en_0, wr_en_1,
        input  wr_addr_0, wr_addr_1, wr_data_0, wr_data_1,
        output rd_data_a, rd_data_b, ready
    );
endinterface

// File: rtl/rf_multi.sv
// Two-read / two-write register file with an index-sweep clear FSM.
// Storage has no reset; CLEAR zeroes one register per cycle and ready rises once the sweep ends.
module rf_multi #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1,
    parameter int AW       = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    rf_multi_if.slave     bus,
    output logic          dbg_run_o,
    output logic [AW-1:0] dbg_idx_o
);
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic             ready_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wa0, wa1, ra, rb;
    logic [WIDTH-1:0] wd0, wd1, rd_a, rd_b;
    logic             we0_eff, we1_eff, we0_store;

    assign wa0 = bus.wr_addr_0;
    assign wa1 = bus.wr_addr_1;
    assign wd0 = bus.wr_data_0;
    assign wd1 = bus.wr_data_1;
    assign ra  = bus.rd_addr_a;
    assign rb  = bus.rd_addr_b;

    // Address maps to real, writable storage (excludes hardwired register 0).
    function automatic logic addr_live(input logic [AW-1:0] a);
        return ({1'b0, a} < (AW+1)'(DEPTH)) && !(ZERO_REG && (a == '0));
    endfunction

    assign we0_eff   = ready_q && !bus.clr && bus.wr_en_0 && addr_live(wa0);
    assign we1_eff   = ready_q && !bus.clr && bus.wr_en_1 && addr_live(wa1);
    assign we0_store = we0_eff && !(we1_eff && (wa1 == wa0));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (bus.clr) begin
            state_d = ST_CLEAR;
            idx_d   = '0;
        end else if (state_q == ST_CLEAR) begin
            if (idx_q == LAST_IDX) begin
                state_d = ST_RUN;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            idx_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ready_q <= (state_d == ST_RUN);
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem_q[idx_q] <= '0;
        end else begin
            if (we0_store) mem_q[wa0] <= wd0;
            if (we1_eff)   mem_q[wa1] <= wd1;
        end
    end

    // Port 1 is checked first so it wins the forward when both writes hit the read address.
    function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] a);
        logic [WIDTH-1:0] r;
        r = '0;
        if (!ready_q)                            r = '0;
        else if (BYPASS && we1_eff && a == wa1)  r = wd1;
        else if (BYPASS && we0_eff && a == wa0)  r = wd0;
        else if (addr_live(a))                   r = mem_q[a];
        return r;
    endfunction

    always_comb begin
        rd_a = read_port(ra);
        rd_b = read_port(rb);
    end

    assign bus.rd_data_a = rd_a;
    assign bus.rd_data_b = rd_b;
    assign bus.ready     = ready_q;
    assign dbg_run_o     = (state_q == ST_RUN);
    assign dbg_idx_o     = idx_q;
endmodule
